// File: rtl/uart_pkg.sv
// Shared types and frame constants for the buffered UART transmitter.
// UART_TX_PARITY_EN selects an 8E1 frame (11 bit periods) instead of 8N1.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned UART_FRAME_BITS = 11;
`else
    localparam int unsigned UART_FRAME_BITS = 10;
`endif

    // Keeps the baud counter at least one bit wide for degenerate clock/baud ratios.
    function automatic int unsigned tick_width(input int unsigned period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        push_en  = push && !full;
        pop_en   = pop && !empty;
        wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: ready/valid byte FIFO feeding a fixed-baud serializer.
// Defining UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned TICK_W           = tick_width(SYMBOL_EDGE_TIME);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0] LAST_BIT          = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t    state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              serial_q, serial_d;
    logic              bit_done;
    logic              load_next;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (data_in_valid),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        load_next = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        bit_done  = (tick_q == TICK_LAST);

        unique case (state_q)
            StIdle: load_next = !fifo_empty;
            StStart: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    // Back-to-back frames: reload straight into START with no idle gap.
                    load_next = !fifo_empty;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle) begin
            tick_d = bit_done ? '0 : tick_q + 1'b1;
        end

        if (load_next) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            tick_d   = '0;
            state_d  = StStart;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_rdata;
`endif
        end

        // Line level is registered from the next state so the output never glitches.
        unique case (state_d)
            StStart:  serial_d = 1'b0;
            StData:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: serial_d = parity_d;
`endif
            default:  serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign serial_out    = serial_q;
    assign data_in_ready = !fifo_full;
    assign busy          = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: a cycle-exact line monitor decodes frames and
// compares them against a scoreboard of bytes pushed by the stimulus.
module tb_uart_tx_buffered;

    localparam int unsigned CF    = 50_000_000;
    localparam int unsigned BR    = 115_200;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SET   = CF / BR;
    localparam int unsigned HALF  = SET / 2;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;
    logic [3:0] fifo_count;

    uart_tx_buffered #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic [7:0] sb[$];
    bit         mon_en     = 1'b0;
    bit         mon_active = 1'b0;
    int         mon_cnt;
    int         mon_b;
    logic [7:0] mon_data;
    logic       mon_par;
    logic       last_par;
    logic [7:0] exp_byte;
    int         n_frames = 0;
    bit         first_seen = 1'b0;
    int         first_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    // Cycle-exact receiver: frame start is the first low sample, bits sampled mid-period.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!mon_active) begin
                if (serial_out === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        first_cyc  = cyc;
                    end
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % SET == HALF) begin
                    mon_b = mon_cnt / SET;
                    if (mon_b == 0) begin
                        check("start_bit", serial_out, 1'b0);
                    end else if (mon_b <= 8) begin
                        mon_data[mon_b-1] = serial_out;
                    end else if (mon_b == FB - 1) begin
                        check("stop_bit", serial_out, 1'b1);
                        if (sb.size() == 0) begin
                            check("unexpected_frame", 32'(mon_data), 32'hFFFF_FFFF);
                        end else begin
                            exp_byte = sb.pop_front();
                            check("rx_byte", mon_data, exp_byte);
`ifdef UART_TX_PARITY_EN
                            check("parity_bit", mon_par, ^exp_byte);
`endif
                        end
                        last_par   = mon_par;
                        mon_active = 1'b0;
                        n_frames++;
                    end else begin
                        mon_par = serial_out;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        data_in       = b;
        data_in_valid = 1'b1;
        sb.push_back(b);
        @(negedge clk);
        data_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst    = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        sb.delete();
        mon_active = 1'b0;
        first_seen = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    logic [7:0] byte_v;
    logic       exp_bit;
    int         peak;
    int         t0;
    int         frames0;

    initial begin
        rst           = 1'b0;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_serial", serial_out, 1'b1);
        check("rst_ready", data_in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 4'd0);
        mon_en = 1'b1;

        // Single byte: exact waveform at first and last cycle of every bit period.
        byte_v = 8'hA5;
        push_byte(byte_v);
        check("a5_serial_after_accept", serial_out, 1'b1);
        check("a5_busy_after_accept", busy, 1'b1);
        check("a5_count_after_accept", fifo_count, 4'd1);
        @(negedge clk);
        check("a5_count_after_pop", fifo_count, 4'd0);
        for (int j = 0; j < FB; j++) begin
            if (j == 0) exp_bit = 1'b0;
            else if (j <= 8) exp_bit = byte_v[j-1];
            else if (j == FB - 1) exp_bit = 1'b1;
            else exp_bit = ^byte_v;
            check($sformatf("a5_bit%0d_first", j), serial_out, exp_bit);
            repeat (SET - 1) @(negedge clk);
            check($sformatf("a5_bit%0d_last", j), serial_out, exp_bit);
            if (j == FB - 1) check("a5_busy_last_stop_cycle", busy, 1'b1);
            @(negedge clk);
        end
        check("a5_busy_fall", busy, 1'b0);
        check("a5_idle_line", serial_out, 1'b1);
        check("a5_frames", n_frames, 1);

        // Fill: nine back-to-back pushes, one pops at once, eight stay buffered.
        do_reset();
        peak = 0;
        for (int i = 0; i < 9; i++) begin
            data_in       = 8'(i);
            data_in_valid = 1'b1;
            sb.push_back(8'(i));
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        data_in_valid = 1'b0;
        check("fill_count", fifo_count, 4'd8);
        check("fill_peak", peak, 8);
        check("fill_ready_low", data_in_ready, 1'b0);
        frames0 = n_frames;
        wait_idle(9 * FB * SET + 200);
        check("fill_contiguous_cycles", cyc - first_cyc, 9 * FB * SET);
        check("fill_frames", n_frames - frames0, 9);
        check("fill_sb_drained", sb.size(), 0);

        // Push on the exact pop edge with three bytes buffered.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data_in       = 8'h10 + 8'(i);
            data_in_valid = 1'b1;
            sb.push_back(8'h10 + 8'(i));
            @(negedge clk);
        end
        data_in_valid = 1'b0;
        check("pp_count_before", fifo_count, 4'd3);
        repeat (FB * SET - 3) @(negedge clk);
        check("pp_count_pre_edge", fifo_count, 4'd3);
        check("pp_line_stop", serial_out, 1'b1);
        push_byte(8'h44);
        check("pp_count_after", fifo_count, 4'd3);
        check("pp_next_start", serial_out, 1'b0);
        wait_idle(5 * FB * SET + 200);
        check("pp_sb_drained", sb.size(), 0);

        // Reset in the middle of DATA bit 3 of 0x00.
        do_reset();
        push_byte(8'h00);
        repeat (1 + 4 * SET + 200) @(negedge clk);
        check("mid_line_low", serial_out, 1'b0);
        mon_en = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        check("mid_rst_serial", serial_out, 1'b1);
        check("mid_rst_count", fifo_count, 4'd0);
        check("mid_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_rst_hold_line", serial_out, 1'b1);
        rst        = 1'b1;
        sb.delete();
        mon_active = 1'b0;
        @(negedge clk);
        check("mid_release_line", serial_out, 1'b1);
        mon_en  = 1'b1;
        frames0 = n_frames;
        push_byte(8'h55);
        wait_idle(FB * SET + 200);
        check("mid_new_frame", n_frames - frames0, 1);
        check("mid_sb_drained", sb.size(), 0);

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07);
        t0 = cyc;
        wait_idle(FB * SET + 200);
        check("par07_frame_cycles", cyc - t0, 1 + 4774);
        check("par07_parity", last_par, 1'b1);
        push_byte(8'h03);
        wait_idle(FB * SET + 200);
        check("par03_parity", last_par, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that drives the serial line toward the CPU's `serial_in` during simulation and bring-up. It accepts bytes over a ready/valid interface into a small FIFO and serializes them 8N1, LSB first, at a fixed baud. It is the transmitting end of the link whose receiving end sits inside the CPU. Benches use it in place of tying `serial_in` high, and a board top can instantiate it for host-side loopback.

## Interface
Parameters:
- `CLOCK_FREQ`, 50_000_000, clock frequency in Hz
- `BAUD_RATE`, 115_200, line rate in bits/s
- `FIFO_DEPTH`, 8, byte FIFO entries; power of two, ≥ 2

Ports:
- `clk`  input  1  single clock; all logic on its rising edge
- `rst`  input  1  reset, synchronous and active-low (asserted when 0)
- `data_in`  input  8  byte to send
- `data_in_valid`  input  1  `data_in` is valid
- `data_in_ready`  output  1  FIFO can accept a byte
- `serial_out`  output  1  UART line; idles high
- `busy`  output  1  a frame is on the line, or the FIFO is non-empty
- `fifo_count`  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered

## Operation
- Bit period: `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` cycles, using integer truncation. The tick counter width is $clog2(SYMBOL_EDGE_TIME).
- Handshake: a byte is accepted on a rising edge where `data_in_valid && data_in_ready`. `data_in_ready = (fifo_count != FIFO_DEPTH)`. There is no combinational path from `data_in_valid` to `data_in_ready`.
- FSM states and transitions:
  - IDLE → START when the FIFO is non-empty. The head byte is popped into the shift register.
  - START: line low for one bit period → DATA.
  - DATA: bits 0..7, LSB first, one bit period each → STOP (or → PARITY when configured).
  - STOP: line high for one bit period. Then → START if the FIFO is non-empty, with no idle gap; otherwise → IDLE.
- Push and pop in the same cycle: both take effect, and `fifo_count` is unchanged.
- Full FIFO: `data_in_ready` is low. A valid byte is held by the producer and nothing is dropped.
- Reset values: `serial_out` = 1, `data_in_ready` = 1, `busy` = 0, `fifo_count` = 0; FSM in IDLE; pointers and counters cleared.
- Reset asserted mid-frame:
  - On the next edge `serial_out` = 1 and the FIFO is flushed.
  - The partial frame is abandoned and produces no glitch low.

## Timing
- Byte accepted at edge N with the FIFO empty and the FSM in IDLE:
  - The FIFO write lands at edge N.
  - The pop and START entry happen at edge N+1.
  - `serial_out` goes low after edge N+1.
- Each bit lasts exactly `SYMBOL_EDGE_TIME` cycles. A frame is 10 × `SYMBOL_EDGE_TIME` cycles (11 × with parity).
- `busy` rises the cycle after acceptance. It falls the cycle after the STOP period ends with the FIFO empty.
- `fifo_count` updates the cycle after the push or pop edge.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits the even-parity bit, the XOR of the 8 data bits, for one bit period.
  - The frame is 11 bit periods.
- Undefined:
  - There is no PARITY state and the frame is 8N1, 10 bit periods.
  - The parity logic is absent from the netlist.

## Structure
- Package `uart_pkg`:
  - FSM state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - Frame-length constants `UART_DATA_BITS = 8` and `UART_FRAME_BITS` (10 or 11, selected by the macro).
- Sub-module `uart_fifo`:
  - Synchronous single-clock FIFO, parameterized on width and depth.
  - Ports: push/pop, full/empty and count.
  - Pointer wrap uses an extra MSB.
- The top holds the FSM, baud tick counter, bit index and shift register.

## Test plan
All scenarios use `CLOCK_FREQ=50_000_000`, `BAUD_RATE=115_200`, so `SYMBOL_EDGE_TIME=434`.
- Reset: hold `rst`=0 for 10 cycles, then release → `serial_out`=1, `data_in_ready`=1, `busy`=0, `fifo_count`=0.
- Single byte 0xA5 → the line is low 434 cycles, then bits 1,0,1,0,0,1,0,1 at 434 cycles each, then high 434 cycles. The start edge falls exactly 1 cycle after acceptance. Total 4340 cycles.
- Fill: push 9 bytes 0x00..0x08 back-to-back from reset → the first pops at once and 8 remain. `fifo_count` peaks at 8 and `data_in_ready` drops while full. All 9 frames are sent contiguously with no idle gap between STOP and START, data in order.
- Simultaneous push/pop: with `fifo_count`=3, push on the exact pop edge → `fifo_count` stays 3.
- Reset mid-frame: assert `rst`=0 during DATA bit 3 of 0x00 → `serial_out`=1 on the next edge and `fifo_count`=0. A new byte 0x55 then transmits cleanly.
- With `UART_TX_PARITY_EN`: byte 0x07 → the parity bit is 1 and the frame is 4774 cycles. Byte 0x03 → the parity bit is 0.
